// File: rtl/retire_trace_buffer_if.sv
// Drain side of the retire trace buffer: FIFO head fields plus a valid/ready handshake.
interface retire_trace_buffer_if;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_kind;
    logic [31:0] out_inum;
    logic [15:0] out_pc;
    logic [15:0] out_instr;
    logic [3:0]  out_reg;
    logic [15:0] out_value;
    logic [15:0] out_addr;

    modport master (
        output out_valid, out_kind, out_inum, out_pc, out_instr, out_reg, out_value, out_addr,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_kind, out_inum, out_pc, out_instr, out_reg, out_value, out_addr,
        output out_ready
    );
endinterface

// File: rtl/retire_trace_buffer.sv
// Retire-event recorder: classifies every retire cycle, stamps it with an instruction number and
// queues it in a first-word-fall-through FIFO drained over a valid/ready port.
module retire_trace_buffer #(
    parameter int DEPTH      = 16,
    parameter int MAX_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           pc,
    input  logic [15:0]           instr,
    input  logic                  write_reg,
    input  logic [3:0]            dst_reg,
    input  logic [15:0]           dst_data,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [15:0]           mem_addr,
    input  logic [15:0]           mem_data,
    input  logic                  hlt,
    retire_trace_buffer_if.master drain,
    output logic [31:0]           cycle_count,
    output logic [31:0]           inst_count,
    output logic                  overflow,
    output logic                  timeout,
    output logic                  done
);
    localparam int          AW         = $clog2(DEPTH);
    localparam int          CW         = AW + 1;
    localparam logic [31:0] LAST_CYCLE = 32'(MAX_CYCLES - 1);

    localparam logic [2:0] KIND_NOP   = 3'd0;
    localparam logic [2:0] KIND_REG   = 3'd1;
    localparam logic [2:0] KIND_LOAD  = 3'd2;
    localparam logic [2:0] KIND_STORE = 3'd3;
    localparam logic [2:0] KIND_HALT  = 3'd4;

    typedef enum logic [1:0] {ST_CAPTURE, ST_DRAIN, ST_DONE} state_t;

    typedef struct packed {
        logic [2:0]  kind;
        logic [31:0] inum;
        logic [15:0] pc;
        logic [15:0] instr;
        logic [3:0]  rnum;
        logic [15:0] value;
        logic [15:0] addr;
    } entry_t;

    state_t      state;
    entry_t      mem [DEPTH];
    entry_t      event_entry;
    entry_t      head;
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] count;
    logic        capturing;
    logic        empty;
    logic        full;
    logic        pop;
    logic        push;
    logic        drop;

    // Fields that do not belong to the chosen kind stay zero so the trace is unambiguous.
    always_comb begin
        event_entry       = '0;
        event_entry.kind  = KIND_NOP;
        event_entry.inum  = inst_count;
        event_entry.pc    = pc;
        event_entry.instr = instr;
        if (write_reg) begin
            event_entry.kind  = mem_read ? KIND_LOAD : KIND_REG;
            event_entry.rnum  = dst_reg;
            event_entry.value = dst_data;
            if (mem_read) begin
                event_entry.addr = mem_addr;
            end
        end else if (hlt) begin
            event_entry.kind = KIND_HALT;
        end else if (mem_write) begin
            event_entry.kind  = KIND_STORE;
            event_entry.value = mem_data;
            event_entry.addr  = mem_addr;
        end
    end

    assign count     = wr_ptr - rd_ptr;
    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign capturing = (state == ST_CAPTURE);
    assign pop       = !empty && drain.out_ready;
    assign push      = capturing && (!full || pop);
    assign drop      = capturing && full && !pop;
    assign done      = (state == ST_DONE);

    assign head              = mem[rd_ptr[AW-1:0]];
    assign drain.out_valid   = !empty;
    assign drain.out_kind    = empty ? '0 : head.kind;
    assign drain.out_inum    = empty ? '0 : head.inum;
    assign drain.out_pc      = empty ? '0 : head.pc;
    assign drain.out_instr   = empty ? '0 : head.instr;
    assign drain.out_reg     = empty ? '0 : head.rnum;
    assign drain.out_value   = empty ? '0 : head.value;
    assign drain.out_addr    = empty ? '0 : head.addr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= event_entry;
        end
    end

    // A halt ends capture whether or not it fit in the FIFO; timeout only fires without a halt.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_CAPTURE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cycle_count <= '0;
            inst_count  <= '0;
            overflow    <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + CW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + CW'(1);
            end
            if (state != ST_DONE && cycle_count != '1) begin
                cycle_count <= cycle_count + 32'd1;
            end
            case (state)
                ST_CAPTURE: begin
                    inst_count <= inst_count + 32'd1;
                    if (drop) begin
                        overflow <= 1'b1;
                    end
                    if (event_entry.kind == KIND_HALT) begin
                        state <= ST_DRAIN;
                    end else if (cycle_count >= LAST_CYCLE) begin
                        timeout <= 1'b1;
                        state   <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (empty || (count == CW'(1) && pop)) begin
                        state <= ST_DONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_retire_trace_buffer.sv
// Scoreboard bench for retire_trace_buffer: expected entries are queued as events are driven
// and compared against the FIFO head whenever a pop happens.
module tb_retire_trace_buffer;
    localparam int DEPTH = 4;
    localparam int MAX_CYCLES = 8;
    localparam logic [2:0] KIND_NOP = 3'd0, KIND_REG = 3'd1, KIND_LOAD = 3'd2,
                           KIND_STORE = 3'd3, KIND_HALT = 3'd4;

    typedef struct packed {
        logic [2:0]  kind;
        logic [31:0] inum;
        logic [15:0] pc;
        logic [15:0] instr;
        logic [3:0]  rnum;
        logic [15:0] value;
        logic [15:0] addr;
    } entry_t;

    typedef struct packed {
        logic wr, rd, mw, h;
        logic [3:0] dr;
        logic [15:0] dd, ma, md, pc, ins;
        logic [2:0] ek;
    } stim_t;

    logic clk, rst;
    logic [15:0] pc, instr, dst_data, mem_addr, mem_data;
    logic [3:0] dst_reg;
    logic write_reg, mem_read, mem_write, hlt;
    logic [31:0] cycle_count, inst_count;
    logic overflow, timeout, done;

    retire_trace_buffer_if dif ();

    retire_trace_buffer #(.DEPTH(DEPTH), .MAX_CYCLES(MAX_CYCLES)) dut (
        .clk(clk), .rst(rst), .pc(pc), .instr(instr), .write_reg(write_reg),
        .dst_reg(dst_reg), .dst_data(dst_data), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_data(mem_data), .hlt(hlt), .drain(dif),
        .cycle_count(cycle_count), .inst_count(inst_count), .overflow(overflow),
        .timeout(timeout), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    int pops = 0;
    logic [31:0] model_inum = 0;
    entry_t exp_q[$];
    entry_t got;

    function automatic entry_t head_now();
        entry_t e;
        e.kind = dif.out_kind;   e.inum = dif.out_inum;   e.pc = dif.out_pc;
        e.instr = dif.out_instr; e.rnum = dif.out_reg;    e.value = dif.out_value;
        e.addr = dif.out_addr;
        return e;
    endfunction

    function automatic string fmt(input entry_t e);
        return $sformatf("kind=%0d inum=%0d pc=%h instr=%h reg=%0d value=%h addr=%h",
                         e.kind, e.inum, e.pc, e.instr, e.rnum, e.value, e.addr);
    endfunction

    function automatic stim_t mk(input logic wr, rd, mw, h, input logic [3:0] dr,
                                 input logic [15:0] dd, ma, md, p, ins, input logic [2:0] ek);
        stim_t s;
        s.wr = wr; s.rd = rd; s.mw = mw; s.h = h; s.dr = dr; s.dd = dd;
        s.ma = ma; s.md = md; s.pc = p; s.ins = ins; s.ek = ek;
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        write_reg = 0; mem_read = 0; mem_write = 0; hlt = 0; dst_reg = 0;
        dst_data = 0; mem_addr = 0; mem_data = 0; pc = 0; instr = 0;
    endtask

    // Drives one event; the expected entry is queued only if the FIFO (after this cycle's pop) has room.
    task automatic set_event(input stim_t s);
        entry_t e;
        write_reg = s.wr; mem_read = s.rd; mem_write = s.mw; hlt = s.h; dst_reg = s.dr;
        dst_data = s.dd; mem_addr = s.ma; mem_data = s.md; pc = s.pc; instr = s.ins;
        e = '0;
        e.kind = s.ek; e.inum = model_inum; e.pc = s.pc; e.instr = s.ins;
        if (s.ek == KIND_REG || s.ek == KIND_LOAD) begin e.rnum = s.dr; e.value = s.dd; end
        if (s.ek == KIND_STORE) e.value = s.md;
        if (s.ek == KIND_LOAD || s.ek == KIND_STORE) e.addr = s.ma;
        if (exp_q.size() < DEPTH) exp_q.push_back(e);
        model_inum++;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        exp_q.delete();
        model_inum = 0;
    endtask

    task automatic test_reset();
        dif.out_ready = 1'b0;
        do_reset();
        checks++;
        if (dif.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", dif.out_valid); end
        checks++;
        if (head_now() !== '0) begin errors++; $display("[TB] FAIL reset_fields got %s want all 0", fmt(head_now())); end
        checks++;
        if ({cycle_count, inst_count} !== 64'd0) begin errors++; $display("[TB] FAIL reset_counters got %0d/%0d want 0/0", cycle_count, inst_count); end
        checks++;
        if ({overflow, timeout, done} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags got %b want 000", {overflow, timeout, done}); end
    endtask

    task automatic test_basic();
        stim_t tbl[3];
        tbl[0] = mk(1, 0, 0, 0, 4'd3, 16'h1234, 16'h0F0F, 16'h0, 16'h0000, 16'h1111, KIND_REG);
        tbl[1] = mk(0, 0, 1, 0, 4'd7, 16'hDEAD, 16'h0040, 16'h00AA, 16'h0002, 16'h2222, KIND_STORE);
        tbl[2] = mk(0, 0, 0, 1, 4'd0, 16'h0, 16'h0, 16'h0, 16'h0004, 16'hF000, KIND_HALT);
        do_reset();
        dif.out_ready = 1'b1;
        pops = 0;
        for (int c = 0; c < 30 && done !== 1'b1; c++) begin
            if (dif.out_valid && dif.out_ready) begin
                checks++; got = head_now(); pops++;
                if (exp_q.size() == 0) begin errors++; $display("[TB] FAIL basic_entry got %s want none", fmt(got)); end
                else begin
                    if (got !== exp_q[0]) begin errors++; $display("[TB] FAIL basic_entry got %s want %s", fmt(got), fmt(exp_q[0])); end
                    exp_q.delete(0);
                end
            end
            if (c < 3) set_event(tbl[c]); else idle_inputs();
            step();
            if (c == 2) begin
                checks++;
                if (cycle_count !== 32'd3) begin errors++; $display("[TB] FAIL basic_cycles got %0d want 3", cycle_count); end
            end
        end
        checks++;
        if (done !== 1'b1 || pops != 3) begin errors++; $display("[TB] FAIL basic_done got done=%b pops=%0d want 1/3", done, pops); end
        checks++;
        if (cycle_count !== 32'd4) begin errors++; $display("[TB] FAIL basic_frozen_cycles got %0d want 4", cycle_count); end
    endtask

    task automatic test_load_nop();
        stim_t tbl[4];
        tbl[0] = mk(1, 1, 0, 0, 4'd5, 16'hBEEF, 16'h0010, 16'h5555, 16'h0100, 16'hA001, KIND_LOAD);
        tbl[1] = mk(0, 0, 0, 0, 4'd9, 16'h7777, 16'h0030, 16'h6666, 16'h0102, 16'hA002, KIND_NOP);
        tbl[2] = mk(1, 0, 1, 1, 4'd2, 16'h0042, 16'h0050, 16'h0011, 16'h0104, 16'hA003, KIND_REG);
        tbl[3] = mk(0, 0, 1, 1, 4'd1, 16'h0001, 16'h0080, 16'h0099, 16'h0106, 16'hA004, KIND_HALT);
        do_reset();
        dif.out_ready = 1'b1;
        pops = 0;
        for (int c = 0; c < 30 && done !== 1'b1; c++) begin
            if (dif.out_valid && dif.out_ready) begin
                checks++; got = head_now(); pops++;
                if (exp_q.size() == 0) begin errors++; $display("[TB] FAIL loadnop_entry got %s want none", fmt(got)); end
                else begin
                    if (got !== exp_q[0]) begin errors++; $display("[TB] FAIL loadnop_entry got %s want %s", fmt(got), fmt(exp_q[0])); end
                    exp_q.delete(0);
                end
            end
            if (c < 4) set_event(tbl[c]); else idle_inputs();
            step();
        end
        checks++;
        if (done !== 1'b1 || pops != 4) begin errors++; $display("[TB] FAIL loadnop_done got done=%b pops=%0d want 1/4", done, pops); end
    endtask

    task automatic test_overflow();
        do_reset();
        dif.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_event(mk(1, 0, 0, 0, 4'(i), 16'(16'h0100 + i), 16'h0, 16'h0, 16'(2 * i), 16'h3000, KIND_REG));
            step();
        end
        checks++;
        if (overflow !== 1'b1 || inst_count !== 32'd6) begin errors++; $display("[TB] FAIL ovf_flag got overflow=%b inst=%0d want 1/6", overflow, inst_count); end
        set_event(mk(0, 0, 0, 1, 4'd0, 16'h0, 16'h0, 16'h0, 16'h000C, 16'hF000, KIND_HALT));
        step();
        checks++;
        if (done !== 1'b0 || dif.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL ovf_drain_state got done=%b valid=%b want 0/1", done, dif.out_valid); end
        idle_inputs();
        dif.out_ready = 1'b1;
        pops = 0;
        for (int c = 0; c < 20 && done !== 1'b1; c++) begin
            if (dif.out_valid && dif.out_ready) begin
                checks++; got = head_now(); pops++;
                if (exp_q.size() == 0) begin errors++; $display("[TB] FAIL ovf_entry got %s want none", fmt(got)); end
                else begin
                    if (got !== exp_q[0]) begin errors++; $display("[TB] FAIL ovf_entry got %s want %s", fmt(got), fmt(exp_q[0])); end
                    exp_q.delete(0);
                end
            end
            step();
        end
        checks++;
        if (pops != 4 || dif.out_valid !== 1'b0 || done !== 1'b1) begin errors++; $display("[TB] FAIL ovf_pops got pops=%0d valid=%b done=%b want 4/0/1", pops, dif.out_valid, done); end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        dif.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_event(mk(1, 0, 0, 0, 4'(i + 8), 16'(16'h0200 + i), 16'h0, 16'h0, 16'(16'h0040 + i), 16'h4000, KIND_REG));
            step();
        end
        checks++;
        if (overflow !== 1'b0 || dif.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL fullpp_filled got overflow=%b valid=%b want 0/1", overflow, dif.out_valid); end
        dif.out_ready = 1'b1;
        checks++; got = head_now();
        if (got !== exp_q[0]) begin errors++; $display("[TB] FAIL fullpp_entry got %s want %s", fmt(got), fmt(exp_q[0])); end
        exp_q.delete(0);
        set_event(mk(1, 0, 0, 0, 4'd12, 16'h0204, 16'h0, 16'h0, 16'h0044, 16'h4000, KIND_REG));
        step();
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL fullpp_no_overflow got %b want 0", overflow); end
        dif.out_ready = 1'b0;
        set_event(mk(0, 0, 0, 1, 4'd0, 16'h0, 16'h0, 16'h0, 16'h0046, 16'hF000, KIND_HALT));
        step();
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL fullpp_still_full got overflow=%b want 1", overflow); end
        idle_inputs();
        dif.out_ready = 1'b1;
        pops = 0;
        for (int c = 0; c < 20 && done !== 1'b1; c++) begin
            if (dif.out_valid && dif.out_ready) begin
                checks++; got = head_now(); pops++;
                if (exp_q.size() == 0) begin errors++; $display("[TB] FAIL fullpp_entry got %s want none", fmt(got)); end
                else begin
                    if (got !== exp_q[0]) begin errors++; $display("[TB] FAIL fullpp_entry got %s want %s", fmt(got), fmt(exp_q[0])); end
                    exp_q.delete(0);
                end
            end
            step();
        end
        checks++;
        if (pops != 4 || done !== 1'b1) begin errors++; $display("[TB] FAIL fullpp_pops got pops=%0d done=%b want 4/1", pops, done); end
    endtask

    task automatic test_timeout();
        do_reset();
        dif.out_ready = 1'b1;
        pops = 0;
        for (int c = 0; c < 40 && done !== 1'b1; c++) begin
            if (dif.out_valid && dif.out_ready) begin
                checks++; got = head_now(); pops++;
                if (exp_q.size() == 0) begin errors++; $display("[TB] FAIL timeout_entry got %s want none", fmt(got)); end
                else begin
                    if (got !== exp_q[0]) begin errors++; $display("[TB] FAIL timeout_entry got %s want %s", fmt(got), fmt(exp_q[0])); end
                    exp_q.delete(0);
                end
            end
            if (c < 8) set_event(mk(0, 0, 0, 0, 4'd0, 16'h0, 16'h0, 16'h0, 16'(2 * c), 16'h0000, KIND_NOP));
            else idle_inputs();
            step();
            if (c == 6) begin
                checks++;
                if (timeout !== 1'b0) begin errors++; $display("[TB] FAIL timeout_early got %b want 0", timeout); end
            end
            if (c == 7) begin
                checks++;
                if (timeout !== 1'b1 || done !== 1'b0) begin errors++; $display("[TB] FAIL timeout_set got timeout=%b done=%b want 1/0", timeout, done); end
            end
        end
        checks++;
        if (done !== 1'b1 || pops != 8 || inst_count !== 32'd8) begin errors++; $display("[TB] FAIL timeout_done got done=%b pops=%0d inst=%0d want 1/8/8", done, pops, inst_count); end
        repeat (5) step();
        checks++;
        if (cycle_count !== 32'd9) begin errors++; $display("[TB] FAIL timeout_frozen got %0d want 9", cycle_count); end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        dif.out_ready = 1'b0;
        set_event(mk(1, 0, 0, 0, 4'd1, 16'h0011, 16'h0, 16'h0, 16'h0000, 16'h5000, KIND_REG)); step();
        set_event(mk(1, 0, 0, 0, 4'd2, 16'h0022, 16'h0, 16'h0, 16'h0002, 16'h5001, KIND_REG)); step();
        set_event(mk(0, 0, 0, 1, 4'd0, 16'h0, 16'h0, 16'h0, 16'h0004, 16'hF000, KIND_HALT)); step();
        checks++;
        if (done !== 1'b0 || dif.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL mid_drain_state got done=%b valid=%b want 0/1", done, dif.out_valid); end
        do_reset();
        checks++;
        if (dif.out_valid !== 1'b0 || {cycle_count, inst_count} !== 64'd0 || {overflow, timeout, done} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL mid_reset got valid=%b cycles=%0d inst=%0d flags=%b want 0/0/0/000",
                     dif.out_valid, cycle_count, inst_count, {overflow, timeout, done});
        end
        dif.out_ready = 1'b0;
        set_event(mk(1, 0, 0, 0, 4'd6, 16'h0066, 16'h0, 16'h0, 16'h0010, 16'h6000, KIND_REG));
        step();
        checks++;
        if (dif.out_valid !== 1'b1 || dif.out_inum !== 32'd0) begin errors++; $display("[TB] FAIL mid_resume got valid=%b inum=%0d want 1/0", dif.out_valid, dif.out_inum); end
        dif.out_ready = 1'b1;
        pops = 0;
        for (int c = 0; c < 20 && done !== 1'b1; c++) begin
            if (dif.out_valid && dif.out_ready) begin
                checks++; got = head_now(); pops++;
                if (exp_q.size() == 0) begin errors++; $display("[TB] FAIL mid_entry got %s want none", fmt(got)); end
                else begin
                    if (got !== exp_q[0]) begin errors++; $display("[TB] FAIL mid_entry got %s want %s", fmt(got), fmt(exp_q[0])); end
                    exp_q.delete(0);
                end
            end
            if (c == 0) set_event(mk(0, 0, 0, 1, 4'd0, 16'h0, 16'h0, 16'h0, 16'h0012, 16'hF000, KIND_HALT));
            else idle_inputs();
            step();
        end
        checks++;
        if (done !== 1'b1 || pops != 2) begin errors++; $display("[TB] FAIL mid_done got done=%b pops=%0d want 1/2", done, pops); end
    endtask

    initial begin
        rst = 1'b1;
        dif.out_ready = 1'b0;
        idle_inputs();
        test_reset();
        test_basic();
        test_load_nop();
        test_overflow();
        test_full_push_pop();
        test_timeout();
        test_reset_mid_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
